// File: rtl/fetch_stage.sv
// Purpose: instruction-fetch stage; one imem request outstanding, {pc, instr} delivered to decode.
// Latency: IDLE->REQ 1 cycle, gnt->id_valid = rvalid latency + 1; best case 3 cycles/instruction.
// Backpressure: a new fetch starts only when the output register is empty or draining; id_ready low holds the payload.
//
// Ports:
//   CLK, reset_n                   clock (rising edge), asynchronous active-low reset
//   pc_in / pc_next                current PC in; next PC out (redirect > pc+4 on grant > hold)
//   redirect_valid/_target         taken branch/jump; flushes in-flight and buffered fetches
//   imem_req/addr/gnt/rvalid/rdata instruction-memory req/gnt + rvalid handshake
//   id_valid/ready/pc/instr        one-entry valid/ready payload register towards decode

`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module fetch_stage #(
    parameter int              XLEN      = `WORDSIZE,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic            CLK,
    input  logic            reset_n,

    // PC register interface
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,

    // branch/jump redirect
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,

    // instruction memory
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,

    // decode interface
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    // IDLE : no request outstanding, waiting for room in the output register
    // REQ  : request presented, waiting for grant
    // WAIT : granted, waiting for the response that will fill the output register
    // DROP : granted but flushed by a redirect; the response must still be absorbed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;     // PC of the request currently in WAIT
    logic            out_free;     // output register empty or being accepted this cycle
    logic            req_granted;  // handshake completes this cycle
    logic            fill;         // response is written into the output register

    assign out_free    = !id_valid || id_ready;
    assign req_granted = imem_req && imem_gnt;
    // A redirect in the same cycle as the response kills it.
    assign fill        = (state == WAIT) && imem_rvalid && !redirect_valid;

    // The PC register holds the address of the request while it waits for a
    // grant, so the address bus is simply the PC register output.
    assign imem_addr = pc_in;

    // Next PC: the PC register only advances once the memory has accepted the
    // address it currently holds; a redirect always wins.
    always_comb begin
        pc_next = pc_in;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (req_granted) begin
            pc_next = pc_in + XLEN'(4);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            fetch_pc <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
        end else begin
            // ---------------- request sequencing ----------------
            case (state)
                IDLE: begin
                    // Only start when the response is guaranteed a free slot:
                    // nothing can fill the output register between now and
                    // the response except this very fetch.
                    if (out_free && !redirect_valid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end

                REQ: begin
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        if (redirect_valid) begin
                            // Memory took the request; its response is stale.
                            state <= DROP;
                        end else begin
                            state    <= WAIT;
                            fetch_pc <= pc_in;
                        end
                    end else if (redirect_valid) begin
                        // Not yet accepted, so it can simply be withdrawn.
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end

                WAIT: begin
                    // A response always ends the wait (filled or discarded via
                    // 'fill'); a redirect without one leaves a response to absorb.
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end else if (redirect_valid) begin
                        state <= DROP;
                    end
                end

                DROP: begin
                    // Further redirects change nothing: the discarded response
                    // is still the only thing outstanding.
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase

            // ---------------- output register ----------------
            // Priority: flush, then fill, then drain. A fill on the same cycle
            // as a drain replaces the accepted payload without a bubble.
            if (redirect_valid) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end else if (fill) begin
                id_valid <= 1'b1;
                id_pc    <= fetch_pc;
                id_instr <= imem_rdata;
            end else if (id_valid && id_ready) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: self-checking bench for fetch_stage with a PC register, imem and decode model.
// Latency: imem answers a configurable number of cycles after each grant.
// Backpressure: decode ready and imem grant are driven per scenario.
//
// Ports: none (top-level bench); the DUT is fully connected to bench signals.

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(.XLEN(32)) dut (
        .CLK             (CLK),
        .reset_n         (reset_n),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr)
    );

    // Upstream PC register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) pc_in <= '0;
        else          pc_in <= pc_next;
    end

    // Instruction contents are derived from the address so each payload is unique.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    // ---------------- memory model + scoreboard ----------------
    int          lat = 1;       // response delay in cycles after the grant cycle
    bit          busy;
    int          cnt;
    logic [31:0] raddr;
    logic [63:0] sb[$];         // expected {pc, instr} in delivery order
    logic [63:0] exp_item;
    logic [31:0] exp_pc;        // model of the next address to be fetched
    int          n_consumed;

    // Responses are driven just after the rising edge.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        busy        = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            imem_rvalid = 1'b0;
            if (!reset_n) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = tag(raddr);
                    busy        = 1'b0;
                end
            end
        end
    end

    // Handshakes are observed on the falling edge.
    initial begin
        exp_pc     = '0;
        n_consumed = 0;
        forever begin
            @(negedge CLK);
            if (!reset_n) begin
                sb.delete();
                exp_pc = '0;
            end else begin
                if (id_valid && id_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no payload", id_pc, id_instr);
                    end else begin
                        exp_item = sb.pop_front();
                        if ({id_pc, id_instr} !== exp_item) begin
                            errors++;
                            $display("FAIL sb_payload: got pc=%h instr=%h, required pc=%h instr=%h",
                                     id_pc, id_instr, exp_item[63:32], exp_item[31:0]);
                        end
                    end
                    n_consumed++;
                end
                if (imem_req && imem_gnt) begin
                    checks++;
                    if (imem_addr !== exp_pc) begin
                        errors++;
                        $display("FAIL gnt_addr: got %h, required %h", imem_addr, exp_pc);
                    end
                    busy  = 1'b1;
                    cnt   = lat;
                    raddr = imem_addr;
                    sb.push_back({exp_pc, tag(exp_pc)});
                    if (!redirect_valid) begin
                        checks++;
                        if (pc_next !== exp_pc + 32'd4) begin
                            errors++;
                            $display("FAIL gnt_pc_next: got %h, required %h", pc_next, exp_pc + 32'd4);
                        end
                    end
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect_valid) begin
                    sb.delete();
                    exp_pc = redirect_target;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT, required event within budget", name);
    endtask

    // Waits (at falling edges) until imem_req is high; returns 0 on timeout.
    task automatic wait_req(input int budget, input bool_chk_idle, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            if (bool_chk_idle) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL flushed_valid: got id_valid=%b, required 0", id_valid);
                end
            end
        end
    endtask

    task automatic wait_handshake(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (imem_req && imem_gnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h, required 0", id_pc); end
        checks++; if (id_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h, required %h", id_instr, NOP); end
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL rst_pc_next: got %h, required 0", pc_next); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_stream(input int n);
        int start;
        int c;
        lat      = 1;
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        start    = n_consumed;
        c        = 0;
        while (n_consumed < start + n && c < 3 * n + 20) begin
            @(negedge CLK);
            c++;
        end
        checks++;
        if (n_consumed < start + n || c > 3 * n + 3) begin
            errors++;
            $display("FAIL stream_rate: got %0d items in %0d cycles, required %0d within %0d",
                     n_consumed - start, c, n, 3 * n + 3);
        end
        // Stop fetching and let the last outstanding fetch drain.
        tick();
        imem_gnt = 1'b0;
        repeat (8) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got %0d undelivered, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        tick();
        id_ready = 1'b0;
        imem_gnt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (id_valid) begin ok = 1'b1; break; end
        end
        if (!ok || sb.size() == 0) begin
            timeout("bp_fill");
        end else begin
            exp_item = sb[0];
            for (int i = 0; i < 10; i++) begin
                checks++;
                if ({id_pc, id_instr} !== exp_item || id_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_payload: got v=%b pc=%h instr=%h, required v=1 pc=%h instr=%h",
                             id_valid, id_pc, id_instr, exp_item[63:32], exp_item[31:0]);
                end
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b, required 0", imem_req); end
                checks++;
                if (pc_next !== pc_in) begin errors++; $display("FAIL bp_pc_next: got %h, required %h", pc_next, pc_in); end
                @(negedge CLK);
            end
        end
        tick();
        id_ready = 1'b1;
    endtask

    task automatic test_redirect_wait();
        bit ok;
        lat = 3;
        wait_handshake(20, ok);
        if (!ok) begin
            timeout("rw_gnt");
        end else begin
            tick();                       // DUT now in WAIT
            redirect_valid  = 1'b1;
            redirect_target = 32'h100;
            tick();
            redirect_valid  = 1'b0;
            wait_req(20, 1'b1, ok);
            if (!ok) timeout("rw_req");
            else begin
                checks++;
                if (imem_addr !== 32'h100) begin
                    errors++;
                    $display("FAIL rw_addr: got %h, required 00000100", imem_addr);
                end
            end
        end
    endtask

    task automatic test_redirect_gnt();
        bit ok;
        int start;
        tick();
        lat      = 2;
        imem_gnt = 1'b0;
        wait_req(20, 1'b0, ok);
        if (!ok) begin
            timeout("rg_req");
        end else begin
            tick();
            imem_gnt        = 1'b1;
            redirect_valid  = 1'b1;
            redirect_target = 32'h200;
            start           = n_consumed;
            tick();
            redirect_valid  = 1'b0;
            wait_req(20, 1'b1, ok);
            if (!ok) timeout("rg_req2");
            else begin
                checks++;
                if (imem_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL rg_addr: got %h, required 00000200", imem_addr);
                end
                for (int i = 0; i < 20 && n_consumed == start; i++) @(negedge CLK);
                checks++;
                if (n_consumed == start) begin
                    errors++;
                    $display("FAIL rg_deliver: got no delivery, required fetch at 00000200");
                end
            end
        end
    endtask

    task automatic test_gnt_stall();
        bit ok;
        tick();
        lat      = 1;
        imem_gnt = 1'b0;
        wait_req(20, 1'b0, ok);
        if (!ok) begin
            timeout("gs_req");
        end else begin
            for (int i = 0; i < 5; i++) begin
                @(negedge CLK);
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL gs_hold: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, exp_pc);
                end
                checks++;
                if (pc_next !== pc_in) begin
                    errors++;
                    $display("FAIL gs_pc_next: got %h, required %h", pc_next, pc_in);
                end
            end
        end
        tick();
        imem_gnt = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    task automatic test_reset_async();
        bit ok;
        lat      = 3;
        imem_gnt = 1'b1;
        id_ready = 1'b1;
        wait_handshake(20, ok);
        if (!ok) begin
            timeout("ra_gnt");
        end else begin
            @(posedge CLK);
            #3;                           // in WAIT, mid-cycle
            reset_n = 1'b0;
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_req: got %b, required 0", imem_req); end
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ra_valid: got %b, required 0", id_valid); end
            checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL ra_pc: got %h, required 0", id_pc); end
            checks++; if (id_instr !== NOP) begin errors++; $display("FAIL ra_instr: got %h, required %h", id_instr, NOP); end
            checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL ra_pc_next: got %h, required 0", pc_next); end
        end
        reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_gnt        = 1'b1;
        id_ready        = 1'b1;
        test_reset();
        test_stream(6);
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_gnt_stall();
        test_reset_async();
        test_stream(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
